// File: rtl/cp0_unit.sv
// Coprocessor-0 interrupt unit: SR/Cause/EPC/PRId storage, IP sampling with
// per-line sticky latching, and the single interrupt request to the core.
module cp0_unit #(
    parameter logic [31:0] PRID        = 32'h0000_3000,
    parameter logic [5:0]  STICKY_MASK = 6'b000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [29:0] pc,
    input  logic [5:0]  hwint,
    input  logic        exl_set,
    input  logic        exl_clr,
    output logic        int_req,
    output logic [29:0] epc_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_q,  im_d;
    logic        ie_q,  ie_d;
    logic        exl_q, exl_d;
    logic [5:0]  ip_q,  ip_d;
    logic [29:0] epc_q, epc_d;

    logic        wr_sr_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic [5:0]  ip_clr_s;

    // Write decode and next-state selection for all CP0 registers.
    always_comb begin
        wr_sr_s    = we & (cp0_addr == ADDR_SR);
        wr_cause_s = we & (cp0_addr == ADDR_CAUSE);
        wr_epc_s   = we & (cp0_addr == ADDR_EPC);

        // Writing 0 to an IP bit clears it; only sticky bits hold state to clear.
        ip_clr_s = {6{wr_cause_s}} & ~din[15:10];
        ip_d     = hwint | (ip_q & ~ip_clr_s & STICKY_MASK);

        if (wr_sr_s) begin
            im_d = din[15:10];
            ie_d = din[0];
        end else begin
            im_d = im_q;
            ie_d = ie_q;
        end

        // Exception entry outranks eret, which outranks a software EXL write.
        if (exl_set) begin
            exl_d = 1'b1;
        end else if (exl_clr) begin
            exl_d = 1'b0;
        end else if (wr_sr_s) begin
            exl_d = din[1];
        end else begin
            exl_d = exl_q;
        end

        if (exl_set) begin
            epc_d = pc;
        end else if (wr_epc_s) begin
            epc_d = din[31:2];
        end else begin
            epc_d = epc_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= 6'b000000;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            ip_q  <= 6'b000000;
            epc_q <= 30'h0000_0000;
        end else begin
            im_q  <= im_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    // mfc0 read mux; unmapped addresses read zero.
    always_comb begin
        case (cp0_addr)
            ADDR_SR:    dout = {16'h0000, im_q, 8'h00, exl_q, ie_q};
            ADDR_CAUSE: dout = {16'h0000, ip_q, 10'h000};
            ADDR_EPC:   dout = {epc_q, 2'b00};
            ADDR_PRID:  dout = PRID;
            default:    dout = 32'h0000_0000;
        endcase
    end

    // Request derives from registered state only, so hwint never reaches it combinationally.
    assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: scoreboard queues hold expected read data
// and request levels, drained and compared as the DUT produces them.
module tb_cp0_unit;

    localparam logic [31:0] PRID_EXP = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [29:0] pc;
    logic [5:0]  hwint;
    logic        exl_set;
    logic        exl_clr;
    logic        int_req;
    logic [29:0] epc_out;

    int n_checks;
    int n_errors;

    logic [4:0]  rd_addr_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        irq_exp_q[$];

    cp0_unit #(
        .PRID        (PRID_EXP),
        .STICKY_MASK (6'b000001)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .cp0_addr (cp0_addr),
        .din      (din),
        .dout     (dout),
        .pc       (pc),
        .hwint    (hwint),
        .exl_set  (exl_set),
        .exl_clr  (exl_clr),
        .int_req  (int_req),
        .epc_out  (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_addr = a;
        din      = d;
        we       = 1'b1;
        tick();
        we       = 1'b0;
        din      = 32'h0000_0000;
    endtask

    task automatic push_read(input logic [4:0] a, input logic [31:0] e, input string n);
        rd_addr_q.push_back(a);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
    endtask

    task automatic test_reset();
        logic [31:0] exp_v;
        string nm;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_int_req: got %b want 0", int_req);
        end
        n_checks++;
        if (epc_out !== 30'h0) begin
            n_errors++;
            $display("FAIL reset_epc_out: got %h want 0", epc_out);
        end
        push_read(5'd12, 32'h0000_0000, "reset_sr");
        push_read(5'd13, 32'h0000_0000, "reset_cause");
        push_read(5'd14, 32'h0000_0000, "reset_epc");
        push_read(5'd15, PRID_EXP,      "reset_prid");
        push_read(5'd0,  32'h0000_0000, "reset_addr0");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
    endtask

    task automatic test_timer_pulse();
        logic [31:0] exp_v;
        string nm;
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001;
        tick();
        hwint = 6'b000000;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++;
            $display("FAIL timer_irq_next: got %b want 1", int_req);
        end
        tick();
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++;
            $display("FAIL timer_irq_hold: got %b want 1", int_req);
        end
        push_read(5'd13, 32'h0000_0400, "timer_cause");
        push_read(5'd12, 32'h0000_0401, "timer_sr");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
    endtask

    task automatic test_enter_return();
        logic [31:0] exp_v;
        string nm;
        pc      = 30'h0000_0C05;
        exl_set = 1'b1;
        tick();
        exl_set = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL enter_int_req: got %b want 0", int_req);
        end
        n_checks++;
        if (epc_out !== 30'h0000_0C05) begin
            n_errors++;
            $display("FAIL enter_epc_out: got %h want 00000c05", epc_out);
        end
        push_read(5'd14, 32'h0000_3014, "enter_epc");
        push_read(5'd12, 32'h0000_0403, "enter_sr");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
        mtc0(5'd13, 32'h0000_0000);
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL return_int_req: got %b want 0", int_req);
        end
        push_read(5'd12, 32'h0000_0401, "return_sr");
        push_read(5'd13, 32'h0000_0000, "return_cause");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
    endtask

    task automatic test_sticky_clear();
        hwint    = 6'b000001;
        cp0_addr = 5'd13;
        din      = 32'h0000_0000;
        we       = 1'b1;
        tick();
        we       = 1'b0;
        hwint    = 6'b000000;
        cp0_addr = 5'd13;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0400) begin
            n_errors++;
            $display("FAIL sticky_set_wins: dout=%h want 00000400", dout);
        end
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++;
            $display("FAIL sticky_set_irq: got %b want 1", int_req);
        end
        mtc0(5'd13, 32'h0000_0000);
        cp0_addr = 5'd13;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL sticky_cleared: dout=%h want 00000000", dout);
        end
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL sticky_clear_irq: got %b want 0", int_req);
        end
    endtask

    task automatic test_level_line();
        logic exp_irq;
        mtc0(5'd12, 32'h0000_0801);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL level_idle_irq: got %b want 0", int_req);
        end
        for (int k = 0; k < 5; k++) begin
            hwint[1] = (k < 3);
            irq_exp_q.push_back(k < 3);
            tick();
            exp_irq = irq_exp_q.pop_front();
            n_checks++;
            if (int_req !== exp_irq) begin
                n_errors++;
                $display("FAIL level_irq_cycle%0d: got %b want %b", k, int_req, exp_irq);
            end
        end
        hwint = 6'b000010;
        tick();
        mtc0(5'd13, 32'h0000_0000);
        cp0_addr = 5'd13;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0800) begin
            n_errors++;
            $display("FAIL level_ignores_clear: dout=%h want 00000800", dout);
        end
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++;
            $display("FAIL level_irq_after_clear: got %b want 1", int_req);
        end
        hwint = 6'b000000;
        tick();
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL level_drop_irq: got %b want 0", int_req);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_v;
        string nm;
        pc       = 30'h0000_0100;
        exl_set  = 1'b1;
        exl_clr  = 1'b1;
        cp0_addr = 5'd14;
        din      = 32'h1234_5678;
        we       = 1'b1;
        tick();
        we       = 1'b0;
        exl_set  = 1'b0;
        exl_clr  = 1'b0;
        n_checks++;
        if (epc_out !== 30'h0000_0100) begin
            n_errors++;
            $display("FAIL prio_epc_out: got %h want 00000100", epc_out);
        end
        push_read(5'd14, 32'h0000_0400, "prio_epc");
        push_read(5'd12, 32'h0000_0803, "prio_sr");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
        // One-cycle pulses on both a sticky and a level line while EXL is set.
        hwint = 6'b000011;
        tick();
        hwint = 6'b000000;
        tick();
        cp0_addr = 5'd13;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0400) begin
            n_errors++;
            $display("FAIL exl_pulse_capture: dout=%h want 00000400", dout);
        end
        cp0_addr = 5'd12;
        din      = 32'h0000_0403;
        we       = 1'b1;
        exl_clr  = 1'b1;
        tick();
        we       = 1'b0;
        exl_clr  = 1'b0;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++;
            $display("FAIL eret_rerequest: got %b want 1", int_req);
        end
        cp0_addr = 5'd12;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0401) begin
            n_errors++;
            $display("FAIL eret_beats_sr_exl: dout=%h want 00000401", dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_v;
        string nm;
        pc      = 30'h0000_0055;
        exl_set = 1'b1;
        hwint   = 6'b000011;
        tick();
        exl_set = 1'b0;
        cp0_addr = 5'd13;
        #1;
        n_checks++;
        if (dout !== 32'h0000_0C00) begin
            n_errors++;
            $display("FAIL premid_cause: dout=%h want 00000c00", dout);
        end
        rst   = 1'b1;
        hwint = 6'b000000;
        tick();
        rst   = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_rst_irq: got %b want 0", int_req);
        end
        n_checks++;
        if (epc_out !== 30'h0) begin
            n_errors++;
            $display("FAIL mid_rst_epc_out: got %h want 0", epc_out);
        end
        push_read(5'd12, 32'h0000_0000, "mid_rst_sr");
        push_read(5'd13, 32'h0000_0000, "mid_rst_cause");
        push_read(5'd14, 32'h0000_0000, "mid_rst_epc");
        push_read(5'd15, PRID_EXP,      "mid_rst_prid");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
        mtc0(5'd15, 32'hFFFF_FFFF);
        mtc0(5'd20, 32'hFFFF_FFFF);
        push_read(5'd15, PRID_EXP,      "prid_readonly");
        push_read(5'd20, 32'h0000_0000, "unmapped_read");
        push_read(5'd12, 32'h0000_0000, "unmapped_no_alias");
        while (rd_exp_q.size() > 0) begin
            cp0_addr = rd_addr_q.pop_front();
            exp_v    = rd_exp_q.pop_front();
            nm       = rd_name_q.pop_front();
            #1;
            n_checks++;
            if (dout !== exp_v) begin
                n_errors++;
                $display("FAIL %s: dout=%h want %h", nm, dout, exp_v);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        we       = 1'b0;
        cp0_addr = 5'd0;
        din      = 32'h0000_0000;
        pc       = 30'h0;
        hwint    = 6'b000000;
        exl_set  = 1'b0;
        exl_clr  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        test_reset();
        test_timer_pulse();
        test_enter_return();
        test_sticky_clear();
        test_level_line();
        test_priority();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
